spi_slave_tx: RTL and testbench

SPI responder (CPOL=0, CPHA=0) that serves one 32-bit word to the TM4C SPI/SSI master as two consecutive 16-bit frames, MSB first: bits 31:16 in frame 0, bits 15:0 in frame 1. It sits on the FPGA fabric side of the RP–TM4C link and carries synth-engine status and readback data toward the microcontroller. This is the FPGA-to-MCU direction, the counterpart of the 32-bit frame-pair capture path. `sclk` and `csn` come from the master and are asynchronous to `clk`; the block oversamples them.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_sync_edge.sv | 34 +++
 rtl/spi_slave_tx.sv | 140 ++++++++++++++
 tb/tb_spi_slave_tx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI link definitions: frame-pair FSM states, width defaults and bus mode.
package spi_pkg;

  localparam int FRAME_W_DEF = 16;
  localparam int DATA_W_DEF  = 32;

  typedef enum logic [2:0] {
    S_EMPTY,
    S_ARMED,
    S_FRAME0,
    S_GAP,
    S_FRAME1,
    S_DONE
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam spi_mode_t SPI_MODE = '{cpol: 1'b0, cpha: 1'b0};

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizer chain for one asynchronous SPI pin, with single-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter int   STAGES = 2,
  parameter logic IDLE   = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain_q;
  logic              prev_q;

  // NOTE: non-blocking assignments let every stage sample the previous stage's old value,
  // which is what makes this a shift chain rather than a single flop.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      chain_q <= {STAGES{IDLE}};
      prev_q  <= IDLE;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], async_i};
      prev_q  <= chain_q[STAGES-1];
    end
  end

  // Both history flops reset to the idle level, so release of reset never fakes an edge.
  assign sync_o = chain_q[STAGES-1];
  assign rise_o = chain_q[STAGES-1] & ~prev_q;
  assign fall_o = ~chain_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_tx.sv
// SPI mode-0 responder: serves one DATA_W word to the MCU as two FRAME_W frames, MSB first.
module spi_slave_tx
  import spi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int FRAME_W     = FRAME_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              sclk,
  input  logic              csn,
  output logic              miso,
  output logic              miso_oe,
  output logic              busy,
  output logic              done,
  output logic              underrun,
  output logic              abort
);

  localparam int                CNT_W    = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

  logic sclk_s, sclk_rise, sclk_fall;
  logic csn_s, csn_rise, csn_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(SPI_MODE.cpol)) u_sclk_sync (
    .clk(clk), .rstn(rstn), .async_i(sclk),
    .sync_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(1'b1)) u_csn_sync (
    .clk(clk), .rstn(rstn), .async_i(csn),
    .sync_o(csn_s), .rise_o(csn_rise), .fall_o(csn_fall)
  );

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              tail_q, tail_d;

  logic sample_edge, shift_edge, in_frame, handshake;

  assign sample_edge = (SPI_MODE.cpol ^ SPI_MODE.cpha) ? sclk_fall : sclk_rise;
  assign shift_edge  = (SPI_MODE.cpol ^ SPI_MODE.cpha) ? sclk_rise : sclk_fall;
  assign in_frame    = (state_q == S_FRAME0) || (state_q == S_FRAME1);
  assign handshake   = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_EMPTY;
      shift_q   <= '0;
      hold_q    <= '0;
      bit_cnt_q <= '0;
      tail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      hold_q    <= hold_d;
      bit_cnt_q <= bit_cnt_d;
      tail_q    <= tail_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    bit_cnt_d = bit_cnt_q;
    tail_d    = tail_q;
    tx_ready  = (state_q == S_EMPTY);
    busy      = (state_q == S_FRAME0) || (state_q == S_GAP) || (state_q == S_FRAME1);
    done      = 1'b0;
    underrun  = 1'b0;
    abort     = 1'b0;

    // tail_q mutes miso once the last bit's clock has returned to idle; extra bits read 0.
    if (csn_fall) begin
      bit_cnt_d = '0;
      tail_d    = 1'b0;
    end else begin
      if (sample_edge && (bit_cnt_q < CNT_FULL)) bit_cnt_d = bit_cnt_q + 1'b1;
      if ((bit_cnt_q == CNT_FULL) && (sclk_s == SPI_MODE.cpol)) tail_d = 1'b1;
    end

    // Shifting on the 16th falling edge too leaves bit 15 at the MSB for frame 1.
    if (in_frame && shift_edge && (bit_cnt_q != '0)) begin
      shift_d = {shift_q[DATA_W-2:0], 1'b0};
    end

    case (state_q)
      S_EMPTY: begin
        if (handshake) begin
          hold_d  = tx_data;
          shift_d = tx_data;
          state_d = csn_fall ? S_FRAME0 : S_ARMED;
        end else if (csn_fall) begin
          underrun = 1'b1;
        end
      end
      S_ARMED: if (csn_fall) state_d = S_FRAME0;
      S_FRAME0, S_FRAME1: begin
        if (csn_rise) begin
          if (bit_cnt_q == CNT_FULL) begin
            state_d = (state_q == S_FRAME0) ? S_GAP : S_DONE;
          end else begin
            abort   = 1'b1;
            shift_d = hold_q;
            state_d = S_ARMED;
          end
        end
      end
      S_GAP: if (csn_fall) state_d = S_FRAME1;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    miso = 1'b0;
    if (!csn_s) begin
      if (in_frame && !tail_q) begin
        miso = shift_q[DATA_W-1];
      end else if ((state_q == S_EMPTY) && csn_fall && tx_valid) begin
        miso = tx_data[DATA_W-1];
      end
    end
  end

  assign miso_oe = ~csn_s;

endmodule

// File: tb/tb_spi_slave_tx.sv
// Directed bench for spi_slave_tx: a mode-0 master model reads frame pairs and checks status pulses.
module tb_spi_slave_tx;

  localparam int HP  = 8;
  localparam int GAP = 10;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        sclk;
  logic        csn;
  logic        miso;
  logic        miso_oe;
  logic        busy;
  logic        done;
  logic        underrun;
  logic        abort;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int n_done = 0, n_under = 0, n_abort = 0, n_overlap = 0;
  int done_cyc = -1, hs_cyc = -1;

  spi_slave_tx dut (
    .clk(clk), .rstn(rstn), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .sclk(sclk), .csn(csn), .miso(miso), .miso_oe(miso_oe), .busy(busy),
    .done(done), .underrun(underrun), .abort(abort)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
    if (underrun === 1'b1) n_under++;
    if (abort === 1'b1) n_abort++;
    if ((int'(done === 1'b1) + int'(underrun === 1'b1) + int'(abort === 1'b1)) > 1) n_overlap++;
    if ((hs_cyc < 0) && (tx_valid === 1'b1) && (tx_ready === 1'b1) && (rstn === 1'b1)) hs_cyc = cyc;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_word(input logic [31:0] word);
    @(negedge clk);
    tx_data  = word;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // One master frame; optionally presents a word on the csn_fall cycle or pulses reset before bit rst_bit.
  task automatic spi_frame(input int nbits, input bit load, input logic [31:0] word,
                           input int rst_bit, output logic [15:0] rx);
    rx = '0;
    @(negedge clk);
    csn = 1'b0;
    repeat (2) @(negedge clk);
    if (load) begin
      tx_data  = word;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (HP - 3) @(negedge clk);
    end else begin
      repeat (HP - 2) @(negedge clk);
    end
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) begin
        rstn = 1'b0;
        @(negedge clk);
        check("rst_miso", {31'b0, miso}, 32'h0);
        check("rst_ready", {31'b0, tx_ready}, 32'h1);
        rstn = 1'b1;
        @(negedge clk);
      end
      rx   = {rx[14:0], miso};
      sclk = 1'b1;
      repeat (HP) @(negedge clk);
      sclk = 1'b0;
      repeat (HP) @(negedge clk);
    end
    csn = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  initial begin
    logic [15:0] rx;
    int d0, u0, a0;

    rstn     = 1'b0;
    csn      = 1'b1;
    sclk     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;

    // Reset and idle
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("reset_ready", {31'b0, tx_ready}, 32'h1);
    check("reset_miso", {31'b0, miso}, 32'h0);
    check("reset_oe", {31'b0, miso_oe}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    repeat (20) @(negedge clk);
    check("idle_pulses", n_done + n_under + n_abort, 0);

    // Nominal two-frame transfer
    d0 = n_done;
    load_word(32'hA5C3_0F96);
    check("nom_ready_low", {31'b0, tx_ready}, 32'h0);
    check("nom_busy_armed", {31'b0, busy}, 32'h0);
    spi_frame(16, 1'b0, 32'h0, -1, rx);
    check("nom_frame0", {16'h0, rx}, 32'h0000_A5C3);
    check("nom_busy_gap", {31'b0, busy}, 32'h1);
    spi_frame(16, 1'b0, 32'h0, -1, rx);
    check("nom_frame1", {16'h0, rx}, 32'h0000_0F96);
    check("nom_done", n_done - d0, 1);
    check("nom_ready_back", {31'b0, tx_ready}, 32'h1);
    check("nom_busy_end", {31'b0, busy}, 32'h0);

    // Underrun: frame with nothing loaded
    u0 = n_under;
    spi_frame(16, 1'b0, 32'h0, -1, rx);
    check("und_data", {16'h0, rx}, 32'h0);
    check("und_pulse", n_under - u0, 1);
    check("und_ready", {31'b0, tx_ready}, 32'h1);

    // Abort after 7 bits, then full resend
    a0 = n_abort;
    d0 = n_done;
    load_word(32'h1234_5678);
    spi_frame(7, 1'b0, 32'h0, -1, rx);
    check("abt_pulse", n_abort - a0, 1);
    check("abt_partial", {25'h0, rx[6:0]}, 32'h12 >> 1);
    spi_frame(16, 1'b0, 32'h0, -1, rx);
    check("abt_frame0", {16'h0, rx}, 32'h0000_1234);
    spi_frame(16, 1'b0, 32'h0, -1, rx);
    check("abt_frame1", {16'h0, rx}, 32'h0000_5678);
    check("abt_done", n_done - d0, 1);

    // Handshake on the csn_fall cycle, second word held across done
    u0 = n_under;
    spi_frame(16, 1'b1, 32'h8000_0001, -1, rx);
    check("sim_frame0", {16'h0, rx}, 32'h0000_8000);
    check("sim_no_under", n_under - u0, 0);
    tx_data  = 32'hFFFF_FFFF;
    tx_valid = 1'b1;
    hs_cyc   = -1;
    spi_frame(16, 1'b0, 32'h0, -1, rx);
    check("sim_frame1", {16'h0, rx}, 32'h0000_0001);
    check("sim_accept_cyc", hs_cyc, done_cyc + 1);
    tx_valid = 1'b0;

    // Reset during frame 1 bit 5 of the held word
    spi_frame(16, 1'b0, 32'h0, -1, rx);
    check("rmt_frame0", {16'h0, rx}, 32'h0000_FFFF);
    spi_frame(16, 1'b0, 32'h0, 5, rx);
    check("rmt_frame1", {16'h0, rx}, 32'h0000_F800);
    check("rmt_ready", {31'b0, tx_ready}, 32'h1);
    u0 = n_under;
    spi_frame(16, 1'b0, 32'h0, -1, rx);
    check("rmt_next_data", {16'h0, rx}, 32'h0);
    check("rmt_next_under", n_under - u0, 1);

    check("pulse_overlap", n_overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
